csla_addsub_seq: RTL
====================

Name: csla_addsub_seq

Overview:
- Multi-cycle add/subtract unit; the subtract-capable, sequential companion to the combinational 4-bit carry-select adder.
- Processes a WIDTH-bit operation in CHUNK-bit carry-select slices, one slice per clock, with the carry held in a register between slices.
- Uses a valid/ready handshake on both input and output, so it can sit behind a stimulus source and in front of a checker or consumer.

Parameters:
- WIDTH, 16, operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle by the carry-select slice.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  unit can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_sub  input  1  1 = A−B, 0 = A+B
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  sum or difference
- out_cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- out_ovf  output  1  two's-complement signed overflow

Behaviour:
- Constants: N = WIDTH/CHUNK slices.
- FSM states are IDLE, RUN and DONE.
  - IDLE: in_ready=1, out_valid=0. When in_valid is high at a rising edge (accept edge E0), latch in_a, B' = in_sub ? ~in_b : in_b, and carry = in_sub. Clear the slice index to 0 and go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge E1..EN processes slice i = index:
    - Compute sum0/c0 = A[i] + B'[i] + 0 and sum1/c1 = A[i] + B'[i] + 1 in parallel.
    - Select the pair using the carry register.
    - Write the selected sum into result bits [i*CHUNK +: CHUNK] and update carry with the selected carry.
    - Increment index. At edge EN (index = N−1), also compute ovf = carry into MSB XOR carry out of MSB, then go to DONE.
  - DONE: out_valid=1, in_ready=0. out_result, out_cout and out_ovf stay stable until out_valid && out_ready at an edge, then return to IDLE.
- Latency: out_valid rises exactly N edges after the accept edge (4 for the defaults). Throughput is one operation per N+2 cycles at best.
- in_ready is a pure function of state (IDLE only). A new operation offered during DONE is accepted only after the FSM returns to IDLE, never on the same edge as the output handshake.
- Input operands may change after the accept edge without affecting the operation in flight.
- out_result and out_cout are written only by RUN. Between operations they hold their last value; consumers qualify them with out_valid.
- Wrap-around: the result is modulo 2^WIDTH. out_cout carries the lost bit; no saturation.
- Reset, whether asserted at any time including mid-RUN or in DONE, forces:
  - state to IDLE, index to 0, carry to 0;
  - out_result to 0, out_cout to 0, out_ovf to 0, out_valid to 0;
  - in_ready to 1 once reset is released.
  - An in-flight operation is discarded, and no partial result is ever presented.
- N=1 (WIDTH=CHUNK) is legal: RUN lasts one cycle.

Decomposition:
- Shared package csla_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - default WIDTH and CHUNK constants;
  - a function giving the index width, $clog2(N), with a minimum of 1.
- One sub-module is natural: csla_slice, a combinational CHUNK-bit carry-select slice.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb_in (carry into the slice MSB, used for overflow).
  - It contains two ripple adders (carry-in 0 and carry-in 1) and a 2:1 mux.

Test Plan:
1. sub, A=0x0005, B=0x0003 → out_result=0x0002, out_cout=1, out_ovf=0; out_valid rises exactly 4 edges after the accept edge.
2. sub, A=0x0003, B=0x0005 → out_result=0xFFFE, out_cout=0 (borrow), out_ovf=0; also sub, A=0x8000, B=0x0001 → 0x7FFF, out_cout=1, out_ovf=1.
3. add, A=0x7FFF, B=0x0001 → 0x8000, out_cout=0, out_ovf=1. Add, A=0xFFFF, B=0x0001 → 0x0000, out_cout=1, out_ovf=0. Add, A=0x0F0F, B=0x00F1 → 0x1000, which checks the slice-carry chain across all chunks.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands → outputs stable, in_ready=0, nothing accepted. Raise out_ready → out_valid falls, in_ready rises on the following cycle, and the second operation is accepted there with the correct result.
5. Reset mid-RUN: pulse rst_n low for 1 cycle after slice 1 of A=0x1234, B=0x1111 → outputs immediately 0, out_valid=0. Then in_ready=1, and a fresh add 0x0001+0x0001 yields 0x0002.
6. Operand change after accept: drive A=0x00FF, B=0x0001 (add), then alter in_a/in_b during RUN → result is still 0x0100, out_cout=0.

Source files
------------

// File: rtl/csla_pkg.sv
// Shared definitions for the sequential carry-select add/subtract unit:
// FSM state encoding, default geometry and the slice-index width helper.
package csla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csla_slice.sv
// Combinational CHUNK-bit carry-select slice: two adders (carry-in 0 and 1)
// evaluated in parallel, with the real carry-in picking the result.
module csla_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK-1:0] sum0, sum1;
    logic             c0, c1;

    assign {c0, sum0} = {1'b0, a} + {1'b0, b};
    assign {c1, sum1} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, 1'b1};

    assign sum  = cin ? sum1 : sum0;
    assign cout = cin ? c1   : c0;

    // A sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    assign c_msb_in = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/csla_addsub_seq.sv
// Multi-cycle add/subtract: one CHUNK-bit carry-select slice per clock,
// carry held in a register between slices, valid/ready on both sides.
module csla_addsub_seq
    import csla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = idx_width(N);

    state_t           state, state_nx;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry;
    logic             last;

    logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
    logic             sl_cout, sl_cmsb;

    assign sl_a = a_q[idx*CHUNK +: CHUNK];
    assign sl_b = b_q[idx*CHUNK +: CHUNK];
    assign last = (idx == IW'(N - 1));

    csla_slice #(.CHUNK(CHUNK)) u_slice (
        .a        (sl_a),
        .b        (sl_b),
        .cin      (carry),
        .sum      (sl_sum),
        .cout     (sl_cout),
        .c_msb_in (sl_cmsb)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: default assignment first so no path through the case leaves state_nx unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // NOTE: every datapath register, operands included, is reset so an aborted operation leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            out_result <= '0;
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry chain with 1.
                    a_q   <= in_a;
                    b_q   <= in_sub ? ~in_b : in_b;
                    carry <= in_sub;
                    idx   <= '0;
                end
                RUN: begin
                    out_result[idx*CHUNK +: CHUNK] <= sl_sum;
                    carry <= sl_cout;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        out_cout <= sl_cout;
                        out_ovf  <= sl_cmsb ^ sl_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
